// File: rtl/pipe_add_sub.sv
// pipe_add_sub
// Pipelined two's-complement adder/subtractor with a valid/ready stream
// handshake. The WIDTH-bit carry chain is cut into STAGES slices of
// SLICE = WIDTH/STAGES bits, with a register after each slice, so the longest
// combinational carry path is SLICE bits and throughput is one beat per clock.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous, active-high reset (priority over the pipeline enable)
//   in_valid   : operand beat offered
//   in_ready   : block accepts the beat this cycle
//   in_a, in_b : operands (WIDTH bits)
//   in_sub     : 0 = A + B + ci, 1 = A - B - ci
//   in_ci      : carry-in (add) / borrow-in (subtract)
//   out_valid  : result beat available
//   out_ready  : consumer takes the result this cycle
//   out_s      : result (WIDTH bits)
//   out_co     : carry-out (add) / NOT borrow (subtract)
//   out_ov     : signed overflow
//
// Handshake: a beat moves across an interface on a rising edge where both
// valid and ready are high. valid never depends on ready. The whole pipeline
// advances together when en = out_ready || !out_valid; in_ready is exactly en,
// so it follows out_ready combinationally. Bubbles advance with the pipeline
// and are never compressed. While en = 0 every stage register holds.
//
// Stage k (0 = LSB slice) registers: its valid bit, the carry out of slice k,
// the result bits computed so far ([0 +: (k+1)*SLICE]) and, except for the last
// stage, the operand bits not yet consumed. The last stage also registers the
// signed-overflow flag, derived from the top slice only.
module pipe_add_sub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_co,
  output logic             out_ov
);

  localparam int SLICE = WIDTH / STAGES;

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             carry0;

  assign en       = out_ready || !out_valid;
  assign in_ready = en;

  // Subtraction is A + ~B + ~ci: the inverted borrow-in doubles as the +1 of
  // the two's complement of B, so carry-out = 1 means "no borrow".
  assign b_eff  = in_sub ? ~in_b : in_b;
  assign carry0 = in_sub ? ~in_ci : in_ci;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO  = k * SLICE;       // first result bit produced here
    localparam int REM = WIDTH - LO;      // operand bits still to be consumed

    logic [REM-1:0]      a_op;
    logic [REM-1:0]      b_op;
    logic                c_in;
    logic                v_in;
    logic [SLICE:0]      sum;
    logic [LO+SLICE-1:0] s_d;
    logic [LO+SLICE-1:0] s_q;
    logic                v_q;
    logic                c_q;

    if (k == 0) begin : g_src
      assign a_op = in_a;
      assign b_op = b_eff;
      assign c_in = carry0;
      assign v_in = in_valid;
      assign s_d  = sum[SLICE-1:0];
    end else begin : g_src
      assign a_op = g_stage[k-1].g_fwd.a_q;
      assign b_op = g_stage[k-1].g_fwd.b_q;
      assign c_in = g_stage[k-1].c_q;
      assign v_in = g_stage[k-1].v_q;
      assign s_d  = {sum[SLICE-1:0], g_stage[k-1].s_q};
    end

    // The only combinational carry chain in the block: SLICE bits wide.
    assign sum = {1'b0, a_op[SLICE-1:0]} + {1'b0, b_op[SLICE-1:0]}
               + {{SLICE{1'b0}}, c_in};

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (en) begin
        v_q <= v_in;
        c_q <= sum[SLICE];
        s_q <= s_d;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      // Upper operand slices ride along with the beat until their slice runs.
      logic [REM-SLICE-1:0] a_q;
      logic [REM-SLICE-1:0] b_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_op[REM-1:SLICE];
          b_q <= b_op[REM-1:SLICE];
        end
      end
    end else begin : g_last
      // Overflow when both effective operands share a sign and the result
      // sign differs; only the top slice carries the sign bits.
      logic ov_d;
      logic ov_q;

      assign ov_d = (a_op[SLICE-1] == b_op[SLICE-1])
                 && (sum[SLICE-1] != a_op[SLICE-1]);

      always_ff @(posedge clk) begin
        if (rst) begin
          ov_q <= 1'b0;
        end else if (en) begin
          ov_q <= ov_d;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign out_s     = g_stage[STAGES-1].s_q;
  assign out_co    = g_stage[STAGES-1].c_q;
  assign out_ov    = g_stage[STAGES-1].g_last.ov_q;

endmodule

// File: tb/tb_pipe_add_sub.sv
// Bench for pipe_add_sub: a 32/4 instance for directed vectors, randomized
// streaming with backpressure and mid-stream reset, plus 8/1, 8/8 and 64/4
// instances fed an exhaustive 8-bit operand sweep with out_ready held high.
`timescale 1ns/1ps
module tb_pipe_add_sub;

  localparam int S = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- main DUT (32, 4) ----------------
  logic        m_valid, m_ready, m_sub, m_ci;
  logic [31:0] m_a, m_b, m_s;
  logic        m_ovalid, m_oready, m_co, m_ov;
  logic        rdy_rand, rdy_fix, rnd_bit;

  assign m_oready = rdy_rand ? rnd_bit : rdy_fix;

  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  pipe_add_sub #(.WIDTH(32), .STAGES(4)) u_main (
    .clk(clk), .rst(rst),
    .in_valid(m_valid), .in_ready(m_ready),
    .in_a(m_a), .in_b(m_b), .in_sub(m_sub), .in_ci(m_ci),
    .out_valid(m_ovalid), .out_ready(m_oready),
    .out_s(m_s), .out_co(m_co), .out_ov(m_ov)
  );

  // ---------------- sweep DUTs ----------------
  logic        sw_valid, sw_sub, sw_ci;
  logic [63:0] sw_a, sw_b;
  logic        a8_ir, a8_ov_v, a8_co, a8_ovf;
  logic [7:0]  a8_s;
  logic        b8_ir, b8_ov_v, b8_co, b8_ovf;
  logic [7:0]  b8_s;
  logic        c64_ir, c64_ov_v, c64_co, c64_ovf;
  logic [63:0] c64_s;

  pipe_add_sub #(.WIDTH(8), .STAGES(1)) u_s81 (
    .clk(clk), .rst(rst),
    .in_valid(sw_valid), .in_ready(a8_ir),
    .in_a(sw_a[7:0]), .in_b(sw_b[7:0]), .in_sub(sw_sub), .in_ci(sw_ci),
    .out_valid(a8_ov_v), .out_ready(1'b1),
    .out_s(a8_s), .out_co(a8_co), .out_ov(a8_ovf)
  );

  pipe_add_sub #(.WIDTH(8), .STAGES(8)) u_s88 (
    .clk(clk), .rst(rst),
    .in_valid(sw_valid), .in_ready(b8_ir),
    .in_a(sw_a[7:0]), .in_b(sw_b[7:0]), .in_sub(sw_sub), .in_ci(sw_ci),
    .out_valid(b8_ov_v), .out_ready(1'b1),
    .out_s(b8_s), .out_co(b8_co), .out_ov(b8_ovf)
  );

  pipe_add_sub #(.WIDTH(64), .STAGES(4)) u_s644 (
    .clk(clk), .rst(rst),
    .in_valid(sw_valid), .in_ready(c64_ir),
    .in_a(sw_a), .in_b(sw_b), .in_sub(sw_sub), .in_ci(sw_ci),
    .out_valid(c64_ov_v), .out_ready(1'b1),
    .out_s(c64_s), .out_co(c64_co), .out_ov(c64_ovf)
  );

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on w-bit values.
  // Returns {ov, co, s[63:0]}.
  function automatic logic [65:0] ref_op(input int w, input logic [63:0] a,
                                         input logic [63:0] b, input logic sub,
                                         input logic ci);
    logic signed [69:0] span, mask, ua, ub, sa, sb, cv, u, r, lim;
    logic [63:0] s;
    logic        co, ov;
    span = 70'sd1 <<< w;
    mask = span - 70'sd1;
    ua   = $signed({6'd0, a}) & mask;
    ub   = $signed({6'd0, b}) & mask;
    sa   = ua[w-1] ? ua - span : ua;
    sb   = ub[w-1] ? ub - span : ub;
    cv   = ci ? 70'sd1 : 70'sd0;
    if (sub) begin
      u  = ua - ub - cv;
      r  = sa - sb - cv;
      co = (u >= 0);
    end else begin
      u  = ua + ub + cv;
      r  = sa + sb + cv;
      co = (u >= span);
    end
    s   = u[63:0] & mask[63:0];
    lim = span >>> 1;
    ov  = (r >= lim) || (r < -lim);
    return {ov, co, s};
  endfunction

  // ---------------- main scoreboard ----------------
  logic [65:0] exp_q[$];
  int          acc_q[$];
  int          stl_q[$];
  logic [65:0] me;
  int          stall_cnt = 0;
  int          got = 0, sent = 0, dropped = 0;
  logic        head_seen = 1'b0, prev_stall = 1'b0;
  logic [31:0] p_s, last_s;
  logic        p_co, p_ov, last_co, last_ov;

  always @(negedge clk) begin
    if (prev_stall) begin
      check("stall_valid", 64'(m_ovalid), 64'd1);
      check("stall_s", 64'(m_s), 64'(p_s));
      check("stall_co", 64'(m_co), 64'(p_co));
      check("stall_ov", 64'(m_ov), 64'(p_ov));
    end
    check("in_ready", 64'(m_ready), 64'(m_oready || !m_ovalid));
    if (rst) begin
      dropped   += exp_q.size();
      exp_q.delete();
      acc_q.delete();
      stl_q.delete();
      head_seen  = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (m_ovalid) begin
        if (exp_q.size() == 0) begin
          check("main_spurious", 64'd1, 64'd0);
        end else begin
          if (!head_seen) begin
            check("main_lat", 64'(cyc), 64'(acc_q[0] + S + stall_cnt - stl_q[0]));
            head_seen = 1'b1;
          end
          if (m_oready) begin
            me = exp_q.pop_front();
            void'(acc_q.pop_front());
            void'(stl_q.pop_front());
            check("main_s", 64'(m_s), 64'(me[31:0]));
            check("main_co", 64'(m_co), 64'(me[64]));
            check("main_ov", 64'(m_ov), 64'(me[65]));
            last_s  = m_s;
            last_co = m_co;
            last_ov = m_ov;
            got++;
            head_seen = 1'b0;
          end
        end
      end
      if (m_ovalid && !m_oready) stall_cnt++;
      if (m_valid && m_ready) begin
        exp_q.push_back(ref_op(32, {32'd0, m_a}, {32'd0, m_b}, m_sub, m_ci));
        acc_q.push_back(cyc);
        stl_q.push_back(stall_cnt);
      end
      prev_stall = m_ovalid && !m_oready;
      p_s  = m_s;
      p_co = m_co;
      p_ov = m_ov;
    end
  end

  // ---------------- sweep scoreboards ----------------
  logic [65:0] qa[$], qb[$], qc[$];
  int          ta[$], tb[$], tc[$];
  logic [65:0] ea, eb, ec;
  int          cnt_a = 0, cnt_b = 0, cnt_c = 0;

  always @(negedge clk) begin
    if (rst) begin
      qa.delete(); qb.delete(); qc.delete();
      ta.delete(); tb.delete(); tc.delete();
    end else begin
      if (a8_ov_v) begin
        if (qa.size() == 0) check("s81_spurious", 64'd1, 64'd0);
        else begin
          ea = qa.pop_front();
          check("s81_s", 64'(a8_s), 64'(ea[7:0]));
          check("s81_co", 64'(a8_co), 64'(ea[64]));
          check("s81_ov", 64'(a8_ovf), 64'(ea[65]));
          check("s81_lat", 64'(cyc), 64'(ta.pop_front() + 1));
          cnt_a++;
        end
      end
      if (b8_ov_v) begin
        if (qb.size() == 0) check("s88_spurious", 64'd1, 64'd0);
        else begin
          eb = qb.pop_front();
          check("s88_s", 64'(b8_s), 64'(eb[7:0]));
          check("s88_co", 64'(b8_co), 64'(eb[64]));
          check("s88_ov", 64'(b8_ovf), 64'(eb[65]));
          check("s88_lat", 64'(cyc), 64'(tb.pop_front() + 8));
          cnt_b++;
        end
      end
      if (c64_ov_v) begin
        if (qc.size() == 0) check("s644_spurious", 64'd1, 64'd0);
        else begin
          ec = qc.pop_front();
          check("s644_s", c64_s, ec[63:0]);
          check("s644_co", 64'(c64_co), 64'(ec[64]));
          check("s644_ov", 64'(c64_ovf), 64'(ec[65]));
          check("s644_lat", 64'(cyc), 64'(tc.pop_front() + 4));
          cnt_c++;
        end
      end
      if (sw_valid) begin
        check("s81_ready", 64'(a8_ir), 64'd1);
        check("s88_ready", 64'(b8_ir), 64'd1);
        check("s644_ready", 64'(c64_ir), 64'd1);
        if (a8_ir) begin
          qa.push_back(ref_op(8, sw_a, sw_b, sw_sub, sw_ci));
          ta.push_back(cyc);
        end
        if (b8_ir) begin
          qb.push_back(ref_op(8, sw_a, sw_b, sw_sub, sw_ci));
          tb.push_back(cyc);
        end
        if (c64_ir) begin
          qc.push_back(ref_op(64, sw_a, sw_b, sw_sub, sw_ci));
          tc.push_back(cyc);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 right after the accepting edge,
  // with in_valid still high so the caller can chain the next beat.
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic sub, input logic ci);
    int n;
    m_a = a; m_b = b; m_sub = sub; m_ci = ci; m_valid = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (m_ready) break;
    end
    if (n == 200) check("accept_timeout", 64'(n), 64'd0);
    else sent++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 100; n++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) break;
    end
    if (n == 100) check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- directed vectors ----------------
  logic [31:0] da[5], db[5], ds[5];
  logic        dsub[5], dci[5], dco[5], dov[5];

  initial begin
    da   = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'd5,          32'd7};
    db   = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'd7,          32'd5};
    dsub = '{1'b0,          1'b0,          1'b1,          1'b1,           1'b1};
    dci  = '{1'b0,          1'b0,          1'b0,          1'b1,           1'b0};
    ds   = '{32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFD,  32'd2};
    dco  = '{1'b1,          1'b0,          1'b1,          1'b0,           1'b1};
    dov  = '{1'b0,          1'b1,          1'b1,          1'b0,           1'b0};
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    m_valid = 1'b0; m_a = '0; m_b = '0; m_sub = 1'b0; m_ci = 1'b0;
    sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_sub = 1'b0; sw_ci = 1'b0;
    rdy_rand = 1'b0; rdy_fix = 1'b1; rnd_bit = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(m_ovalid), 64'd0);
    check("rst_out_s", 64'(m_s), 64'd0);
    check("rst_out_co", 64'(m_co), 64'd0);
    check("rst_out_ov", 64'(m_ov), 64'd0);
    check("rst_in_ready", 64'(m_ready), 64'd1);
    @(posedge clk);
    #1;

    // Directed corner cases
    for (int i = 0; i < 5; i++) begin
      send(da[i], db[i], dsub[i], dci[i]);
      m_valid = 1'b0;
      drain();
      check($sformatf("dir%0d_s", i), 64'(last_s), 64'(ds[i]));
      check($sformatf("dir%0d_co", i), 64'(last_co), 64'(dco[i]));
      check($sformatf("dir%0d_ov", i), 64'(last_ov), 64'(dov[i]));
    end

    // Back-to-back random beats with random backpressure
    rdy_rand = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    m_valid = 1'b0;
    drain();
    rdy_rand = 1'b0;

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    m_valid = 1'b0;
    rst     = 1'b1;
    rdy_fix = 1'b0;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    rdy_fix = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", 64'(m_ovalid), 64'd0);
    check("rst_mid_s", 64'(m_s), 64'd0);
    check("rst_mid_dropped", 64'(dropped), 64'd3);
    repeat (10) @(posedge clk);
    #1;
    send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    m_valid = 1'b0;
    drain();
    check("main_left", 64'(exp_q.size()), 64'd0);
    check("main_count", 64'(got + dropped), 64'(sent));

    // Parameter sweep: exhaustive 8-bit operand pairs, random upper bits
    @(posedge clk);
    #1;
    for (int i = 0; i < 65536; i++) begin
      logic [15:0] iv;
      iv = 16'(i);
      sw_a = {$urandom, $urandom};
      sw_b = {$urandom, $urandom};
      sw_a[7:0] = iv[15:8];
      sw_b[7:0] = iv[7:0];
      sw_sub = 1'($urandom_range(0, 1));
      sw_ci  = 1'($urandom_range(0, 1));
      sw_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    sw_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("s81_count", 64'(cnt_a), 64'd65536);
    check("s88_count", 64'(cnt_b), 64'd65536);
    check("s644_count", 64'(cnt_c), 64'd65536);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_add_sub.md
# pipe_add_sub

Parametrised, pipelined two's-complement adder/subtractor with a valid/ready stream handshake. The WIDTH-bit carry chain is cut into STAGES equal slices, with a register between slices, so throughput is one operation per clock at any WIDTH. It is the registered, mode-capable successor to the team's combinational ripple-carry parallel adder. It sits between operand producers and any consumer that may apply backpressure.

## Interface
- WIDTH, 32, operand and result width in bits; WIDTH ≥ 1.
- STAGES, 4, number of pipeline slices; 1 ≤ STAGES ≤ WIDTH and WIDTH % STAGES == 0; SLICE = WIDTH/STAGES.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operand beat offered.
- in_ready  output  1  block accepts the beat this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_sub  input  1  0: add, 1: subtract.
- in_ci  input  1  carry-in (add) / borrow-in (subtract).
- out_valid  output  1  result beat available.
- out_ready  input  1  consumer takes the result this cycle.
- out_s  output  WIDTH  result.
- out_co  output  1  carry-out (add); NOT borrow (subtract), i.e. 1 = no borrow.
- out_ov  output  1  signed overflow.

## Operation
- Accept: transfer when in_valid && in_ready. Deliver: transfer when out_valid && out_ready.
- Arithmetic:
  - add: {co,s} = A + B + ci.
  - sub: B' = ~B and carry0 = ~ci, so s = A − B − ci.
  - ov = (A[MSB] == B'[MSB]) && (s[MSB] != A[MSB]), with B' = B for add.
- Slice k (0 = LSB) computes bits [k·SLICE +: SLICE] from its delayed operand slice and the carry registered by slice k−1.
- Operand slices above k travel with the beat through delay registers. Result slices below k travel with the beat the same way.
- Each stage holds a valid bit. Pipeline enable en = out_ready || !out_valid. in_ready = en.
- When en = 0 every stage register, including the valid bits, holds its value.
- When en = 1 all stages advance together. Bubbles (valid = 0) advance as well and are not compressed.
- A beat accepted while in_valid = 0 is not possible. With in_valid = 0 and en = 1, a bubble enters stage 0.
- out_co and out_ov come from the final slice only.
- Outputs are registered, and out_s/out_co/out_ov are meaningful only when out_valid = 1.
- STAGES = 1 degenerates to a single registered full-width adder.

## Timing
- Reset: all valid bits = 0; out_valid = 0, out_s = 0, out_co = 0, out_ov = 0. in_ready = 1 from the first cycle after reset.
- Latency: a beat accepted at edge t appears with out_valid = 1 after edge t+STAGES−1, so it is visible in the cycle following that edge. That is STAGES cycles from accept to the result being presentable, provided there is no stall.
- Throughput: one beat per cycle while out_ready = 1.
- Stall: if out_valid = 1 and out_ready = 0, in_ready drops combinationally in the same cycle. The offered input beat is not taken, and all outputs stay stable until the transfer completes.
- Simultaneous out_ready and in_valid with a full pipeline: the output transfers and the input is accepted in the same cycle.
- rst asserted mid-operation: every in-flight beat is discarded at that edge and outputs take their reset values. rst has priority over en.
- Carry path: the only combinational carry chain is SLICE bits long. No path runs from in_* to out_*.
- in_ready depends combinationally on out_ready.

## Test plan
- WIDTH=32, STAGES=4, add: A=0xFFFFFFFF, B=0x00000001, ci=0 -> out_s=0x00000000, co=1, ov=0, valid exactly 4 cycles after accept. This checks the carry crossing all 3 slice boundaries.
- Signed overflow: A=0x7FFFFFFF, B=1, add, ci=0 -> s=0x80000000, co=0, ov=1. Separately, sub with A=0x80000000, B=1 -> s=0x7FFFFFFF, co=1, ov=1.
- Subtract with borrow: A=5, B=7, sub=1, ci=1 -> s=0xFFFFFFFD, co=0, ov=0. Then A=7, B=5, sub=1, ci=0 -> s=2, co=1.
- Streaming with backpressure: 20 random beats back-to-back, out_ready toggling randomly. All results must match a reference model in order, with none lost or duplicated. out_* must stay stable while stalled, and in_ready must equal out_ready || !out_valid every cycle.
- Reset mid-stream: assert rst for 1 cycle with 3 beats in flight -> next cycle out_valid=0, out_s=0, and none of the 3 beats ever appears. A beat accepted afterwards returns after 4 cycles.
- Parameter sweep: (WIDTH, STAGES) = (8,1), (8,8), (64,4) with exhaustive (8-bit) or random (64-bit) operands -> results match the model, with latency equal to STAGES.
